ps2_rx_frame: RTL

//   Receives PS/2 device-to-host frames from the raw ps2_clk/ps2_data pins and delivers scancode bytes.

---
 rtl/ps2_pkg.sv | 13 +
 rtl/ps2_sync_filter.sv | 46 ++++
 rtl/ps2_rx_frame.sv | 111 +++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } ps2_state_t;

    localparam int PS2_FRAME_BITS = 11;

endpackage

// File: rtl/ps2_sync_filter.sv
// Two-flop synchroniser plus run-length deglitcher for the raw PS/2 clock pin.
module ps2_sync_filter
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin,
    output logic filt,
    output logic fall
);

    logic                  sync1;
    logic                  sync2;
    logic                  filt_d;
    logic [FILTER_LEN-1:0] hist;
    logic [FILTER_LEN-1:0] hist_next;

    // The newest synced sample counts toward the run, so filt moves on the
    // same edge that completes FILTER_LEN equal samples.
    assign hist_next = {hist[FILTER_LEN-2:0], sync2};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= 1'b1;
            sync2  <= 1'b1;
            hist   <= '1;
            filt   <= 1'b1;
            filt_d <= 1'b1;
        end else begin
            sync1  <= pin;
            sync2  <= sync1;
            hist   <= hist_next;
            filt_d <= filt;
            if (hist_next == '0) begin
                filt <= 1'b0;
            end else if (&hist_next) begin
                filt <= 1'b1;
            end
        end
    end

    assign fall = filt_d & ~filt;

endmodule

// File: rtl/ps2_rx_frame.sv
// PS/2 device-to-host frame receiver: conditions the pins, deserialises
// 11-bit frames, checks parity/stop and aborts stalled frames.
module ps2_rx_frame
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] out_byte,
    output logic       new_byte,
    output logic       frame_err,
    output logic       busy
);

    localparam int              WD_W   = $clog2(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES - 1);

    ps2_state_t      state;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift;
    logic            par;
    logic [WD_W-1:0] wd_cnt;
    logic            data_sync1;
    logic            data_sync2;
    logic            fall;
    logic            ps2_clk_filt_unused;

    ps2_sync_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_clk_filter (
        .clk  (clk),
        .rst_n(rst_n),
        .pin  (ps2_clk),
        .filt (ps2_clk_filt_unused),
        .fall (fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_sync1 <= 1'b1;
            data_sync2 <= 1'b1;
        end else begin
            data_sync1 <= ps2_data;
            data_sync2 <= data_sync1;
        end
    end

    // A fall always takes priority over watchdog expiry in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= 3'd0;
            shift     <= 8'h00;
            par       <= 1'b0;
            wd_cnt    <= '0;
            out_byte  <= 8'h00;
            new_byte  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            new_byte  <= 1'b0;
            frame_err <= 1'b0;
            if (fall) begin
                wd_cnt <= '0;
                case (state)
                    IDLE: begin
                        if (!data_sync2) begin
                            state   <= DATA;
                            bit_cnt <= 3'd0;
                        end
                    end
                    DATA: begin
                        shift   <= {data_sync2, shift[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) begin
                            state <= PARITY;
                        end
                    end
                    PARITY: begin
                        par   <= data_sync2;
                        state <= STOP;
                    end
                    STOP: begin
                        if (data_sync2 && (^{shift, par})) begin
                            out_byte <= shift;
                            new_byte <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end else if (state == IDLE) begin
                wd_cnt <= '0;
            end else if (wd_cnt == WD_MAX) begin
                state     <= IDLE;
                frame_err <= 1'b1;
                wd_cnt    <= '0;
            end else if (wd_cnt != '1) begin
                wd_cnt <= wd_cnt + 1'b1;
            end
        end
    end

    assign busy = (state != IDLE);

endmodule
